// File: rtl/term_stream_sequencer_if.sv
// Handshake bundle between the systolic array, the term stream sequencer and the
// downstream accumulator. The master modport is the sequencer side.
interface term_stream_sequencer_if #(
    parameter int unsigned NUM_COE_ARRAY      = 16,
    parameter int unsigned NUM_COMBINED_TERMS = 8
);
    localparam int unsigned LANE_W = $clog2(NUM_COE_ARRAY);

    logic                          systolic_valid;
    logic                          systolic_ready;
    logic [NUM_COE_ARRAY-1:0]      systolic_result;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANE_W-1:0]             out_lane;
    logic [NUM_COMBINED_TERMS-1:0] out_word;
    logic                          out_last;

    modport master (
        input  systolic_valid, systolic_result, out_ready,
        output systolic_ready, out_valid, out_lane, out_word, out_last
    );

    modport slave (
        output systolic_valid, systolic_result, out_ready,
        input  systolic_ready, out_valid, out_lane, out_word, out_last
    );
endinterface

// File: rtl/term_stream_sequencer.sv
// Frames bit-serial systolic term results into per-lane words (MSB first) and
// drains them one lane per accept over a shared valid/ready port.
module term_stream_sequencer #(
    parameter int unsigned NUM_COE_ARRAY      = 16,
    parameter int unsigned NUM_COMBINED_TERMS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    term_stream_sequencer_if.master bus
);
    localparam int unsigned LANE_W = $clog2(NUM_COE_ARRAY);
    localparam int unsigned TERM_W = $clog2(NUM_COMBINED_TERMS + 1);
    localparam int unsigned WORD_W = NUM_COMBINED_TERMS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    state_e                                state_q, state_d;
    logic [NUM_COE_ARRAY-1:0][WORD_W-1:0]  lane_q, lane_d;
    logic [TERM_W-1:0]                     term_cnt_q, term_cnt_d;
    logic [LANE_W-1:0]                     lane_idx_q, lane_idx_d;

    logic                                  sys_ready_q, sys_ready_d;
    logic                                  out_valid_q, out_valid_d;
    logic [LANE_W-1:0]                     out_lane_q, out_lane_d;
    logic [WORD_W-1:0]                     out_word_q, out_word_d;
    logic                                  out_last_q, out_last_d;
    logic                                  busy_q, busy_d;

    logic beat;
    logic accept;

    assign beat   = bus.systolic_valid & sys_ready_q;
    assign accept = out_valid_q & bus.out_ready;

    // Next state, lane shift registers and next-cycle output values.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        term_cnt_d = term_cnt_q;
        lane_idx_d = lane_idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lane_d     = '0;
                    term_cnt_d = '0;
                    lane_idx_d = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (beat) begin
                    for (int unsigned i = 0; i < NUM_COE_ARRAY; i++) begin
                        lane_d[i] = {lane_q[i][WORD_W-2:0], bus.systolic_result[i]};
                    end
                    if (term_cnt_q >= TERM_W'(NUM_COMBINED_TERMS - 1)) begin
                        term_cnt_d = TERM_W'(NUM_COMBINED_TERMS);
                        lane_idx_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        term_cnt_d = term_cnt_q + TERM_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (lane_idx_q == LANE_W'(NUM_COE_ARRAY - 1)) begin
                        lane_idx_d = '0;
                        state_d    = IDLE;
                    end else begin
                        lane_idx_d = lane_idx_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        sys_ready_d = (state_d == COLLECT);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != IDLE);
        out_lane_d  = '0;
        out_word_d  = '0;
        out_last_d  = 1'b0;
        if (state_d == DRAIN) begin
            out_lane_d = lane_idx_d;
            out_word_d = lane_d[lane_idx_d];
            out_last_d = (lane_idx_d == LANE_W'(NUM_COE_ARRAY - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            term_cnt_q  <= '0;
            lane_idx_q  <= '0;
            sys_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            term_cnt_q  <= term_cnt_d;
            lane_idx_q  <= lane_idx_d;
            sys_ready_q <= sys_ready_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.systolic_ready = sys_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_lane       = out_lane_q;
    assign bus.out_word       = out_word_q;
    assign bus.out_last       = out_last_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_term_stream_sequencer.sv
// Bench for term_stream_sequencer: directed scenarios plus randomized frames,
// checked every cycle against a frame-level behavioural model.
module tb_term_stream_sequencer;
    localparam int NL = 16;
    localparam int NT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy;

    term_stream_sequencer_if #(.NUM_COE_ARRAY(NL), .NUM_COMBINED_TERMS(NT)) bus ();

    term_stream_sequencer #(.NUM_COE_ARRAY(NL), .NUM_COMBINED_TERMS(NT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 idle, 1 collecting, 2 draining; words built arithmetically.
    int m_phase;
    int m_cnt;
    int m_lane;
    int m_word [NL];

    int log_lane [$];
    int log_word [$];
    int log_last [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_lane  = 0;
        for (int i = 0; i < NL; i++) m_word[i] = 0;
    endtask

    task automatic model_clock();
        if (!reset) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (start) begin
                    for (int i = 0; i < NL; i++) m_word[i] = 0;
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: if (bus.systolic_valid) begin
                    for (int i = 0; i < NL; i++)
                        m_word[i] = ((m_word[i] * 2) + int'(bus.systolic_result[i])) % 256;
                    m_cnt++;
                    if (m_cnt == NT) begin
                        m_phase = 2;
                        m_lane  = 0;
                    end
                end
                default: if (bus.out_ready) begin
                    if (m_lane == NL - 1) m_phase = 0;
                    else m_lane++;
                end
            endcase
        end
    endtask

    task automatic compare_outputs();
        check("busy",           busy,               (m_phase != 0));
        check("systolic_ready", bus.systolic_ready, (m_phase == 1));
        check("out_valid",      bus.out_valid,      (m_phase == 2));
        check("out_lane",       bus.out_lane,       (m_phase == 2) ? m_lane : 0);
        check("out_word",       bus.out_word,       (m_phase == 2) ? m_word[m_lane] : 0);
        check("out_last",       bus.out_last,       (m_phase == 2 && m_lane == NL - 1));
    endtask

    // One clock: log the accept about to happen, advance model, compare.
    task automatic step();
        if (reset && bus.out_valid && bus.out_ready) begin
            log_lane.push_back(int'(bus.out_lane));
            log_word.push_back(int'(bus.out_word));
            log_last.push_back(int'(bus.out_last));
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic clear_log();
        log_lane.delete();
        log_word.delete();
        log_last.delete();
    endtask

    task automatic do_start();
        start              = 1'b1;
        bus.systolic_valid = 1'($urandom_range(1));
        bus.systolic_result = 16'($urandom);
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic [NL-1:0] res, input logic st);
        start               = st;
        bus.systolic_valid  = 1'b1;
        bus.systolic_result = res;
        step();
        bus.systolic_valid = 1'b0;
        start              = 1'b0;
    endtask

    task automatic stall_cycle();
        bus.systolic_valid  = 1'b0;
        bus.systolic_result = 16'($urandom);
        step();
    endtask

    task automatic drain_all(input int ready_pct, input int hold_lane, input int hold_cycles,
                             input bit start_on_last, input bit rand_start, output int steps);
        int   held;
        logic [7:0] held_word;
        logic ordy;
        logic st;
        steps     = 0;
        held      = 0;
        held_word = '0;
        while (busy && steps < 300) begin
            ordy = ($urandom_range(99) < ready_pct);
            if (bus.out_valid && int'(bus.out_lane) == hold_lane && held < hold_cycles) begin
                if (held == 0) held_word = bus.out_word;
                else begin
                    check("hold_word", bus.out_word, held_word);
                    check("hold_lane", bus.out_lane, hold_lane);
                end
                ordy = 1'b0;
                held++;
            end
            bus.out_ready = ordy;
            st = rand_start ? ($urandom_range(3) == 0) : 1'b0;
            if (start_on_last && bus.out_last && ordy) st = 1'b1;
            start = st;
            step();
            steps++;
        end
        start = 1'b0;
        if (busy) check("drain_timeout", 1, 0);
        if (hold_lane >= 0) check("hold_count", held, hold_cycles);
    endtask

    task automatic check_log_vs_model(input string tag);
        check({tag, "_accepts"}, log_lane.size(), NL);
        for (int i = 0; i < NL && i < log_lane.size(); i++) begin
            check({tag, "_lane"}, log_lane[i], i);
            check({tag, "_word"}, log_word[i], m_word[i]);
            check({tag, "_last"}, log_last[i], (i == NL - 1));
        end
    endtask

    initial begin
        logic [7:0]    pat;
        int            steps;
        logic [NL-1:0] zero16;
        logic [NL-1:0] ones16;
        model_reset();
        zero16 = '0;
        ones16 = '1;
        bus.systolic_valid  = 1'b0;
        bus.systolic_result = '0;
        bus.out_ready       = 1'b0;

        // Reset held with random inputs, then released without start.
        for (int c = 0; c < 4; c++) begin
            start               = 1'($urandom_range(1));
            bus.systolic_valid  = 1'($urandom_range(1));
            bus.systolic_result = 16'($urandom);
            bus.out_ready       = 1'($urandom_range(1));
            step();
        end
        check("reset_busy_literal", busy, 0);
        reset = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.systolic_valid  = 1'($urandom_range(1));
            bus.systolic_result = 16'($urandom);
            step();
        end
        check("idle_busy_literal", busy, 0);

        // Basic frame: lane0 1,0,1,1,0,0,1,0.
        clear_log();
        bus.out_ready = 1'b1;
        pat = 8'hB2;
        do_start();
        for (int k = 0; k < NT; k++) begin
            check("no_valid_before_end", bus.out_valid, 0);
            beat({zero16[NL-1:1], pat[NT-1-k]}, 1'b0);
        end
        check("first_valid_latency", bus.out_valid, 1);
        drain_all(100, -1, 0, 1'b0, 1'b0, steps);
        check("drain_cycles", steps, NL);
        check("frame_cycles", 1 + NT + steps, 25);
        check("lane0_word_B2", (log_word.size() > 0) ? log_word[0] : -1, 8'hB2);
        check("lane15_word_00", (log_word.size() == NL) ? log_word[NL-1] : -1, 0);
        check_log_vs_model("basic");

        // Same frame with input stalls on beats 3-5.
        step();
        clear_log();
        do_start();
        for (int k = 0; k < NT; k++) begin
            if (k == 2) for (int s = 0; s < 3; s++) stall_cycle();
            if (k == NT - 1) check("stall_no_early_drain", bus.out_valid, 0);
            beat({zero16[NL-1:1], pat[NT-1-k]}, 1'b0);
        end
        check("stall_drain_entry", bus.out_valid, 1);
        drain_all(100, -1, 0, 1'b0, 1'b0, steps);
        check("stall_lane0_B2", (log_word.size() > 0) ? log_word[0] : -1, 8'hB2);
        check_log_vs_model("stall");

        // Output backpressure at lane 5.
        step();
        clear_log();
        do_start();
        for (int k = 0; k < NT; k++) beat(16'($urandom), 1'b0);
        drain_all(100, 5, 4, 1'b0, 1'b0, steps);
        check("bp_drain_cycles", steps, NL + 4);
        check_log_vs_model("bp");

        // Start during COLLECT and on the last accept is dropped.
        step();
        clear_log();
        do_start();
        for (int k = 0; k < NT; k++) beat(16'($urandom), (k == 3));
        drain_all(100, -1, 0, 1'b1, 1'b0, steps);
        check("start_on_last_dropped", busy, 0);
        check_log_vs_model("startign");
        clear_log();
        do_start();
        check("start_in_idle_taken", busy, 1);
        for (int k = 0; k < NT; k++) beat(16'($urandom), 1'b0);
        drain_all(70, -1, 0, 1'b0, 1'b1, steps);
        check_log_vs_model("restart");

        // Reset at beat 4, then an all-ones frame.
        step();
        clear_log();
        do_start();
        for (int k = 0; k < 4; k++) beat(ones16, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        step();
        reset = 1'b1;
        step();
        check("abort_no_words", log_lane.size(), 0);
        do_start();
        for (int k = 0; k < NT; k++) beat(ones16, 1'b0);
        drain_all(100, -1, 0, 1'b0, 1'b0, steps);
        check("ones_lane7_FF", (log_word.size() > 7) ? log_word[7] : -1, 8'hFF);
        check_log_vs_model("ones");

        // Randomized frames with stalls, backpressure and stray starts.
        for (int f = 0; f < 20; f++) begin
            for (int g = $urandom_range(2); g > 0; g--) begin
                bus.systolic_valid = 1'($urandom_range(1));
                step();
            end
            clear_log();
            do_start();
            for (int k = 0; k < NT; k++) begin
                while ($urandom_range(99) < 30) stall_cycle();
                beat(16'($urandom), 1'($urandom_range(1)));
            end
            drain_all(60, -1, 0, 1'($urandom_range(1)), 1'b1, steps);
            check_log_vs_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
